lvg_feeder: RTL and testbench
=============================

Name: lvg_feeder

Overview:
Command-driven front end that sits directly upstream of the lvg 4x4 fp32 matrix unit.
- Deserialises a word-serial operand stream into staged 4x4 tiles and commits them atomically onto the lvg L/R/A operand buses.
- Drives lvg's instr port.
- Holds compute opcodes for a fixed latency, then captures lvg's B result.
- Replaces the hand-sequenced stimulus currently used to drive lvg.

Parameters:
EXEC_CYCLES, 16, cycles an EXEC opcode is held on instr before B is sampled (must be >= 1)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_kind  in  2  0=LOAD_L, 1=LOAD_RA, 2=EXEC, 3=reserved
cmd_op  in  8  lvg opcode for EXEC; ignored otherwise
s_valid  in  1  stream word offered
s_ready  out  1  stream word accepted when s_valid && s_ready
s_data  in  32  fp32 element, row-major (word k -> element row k/4, col k%4)
l_tile  out  512  L operand; element k at bits [32*k +: 32]
r_tile  out  512  R operand, same packing
a_tile  out  512  A operand, same packing
instr  out  8  lvg instruction
b_tile  in  512  lvg result, same packing
res_valid  out  1  one-cycle pulse; res_data is fresh
res_data  out  512  captured B tile
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state=IDLE; word counter=0; staging buffers cleared.
  - l_tile, r_tile, a_tile, res_data = 0; instr=0; res_valid=0.
  - cmd_ready=1 after reset releases; s_ready=0.
  - Reset mid-operation discards all partial stream data and any pending EXEC, with no commit and no res_valid.
- States: IDLE, FILL_L, FILL_R, FILL_A, COMMIT_L, COMMIT_RA, EXEC, CAPTURE.
- IDLE:
  - cmd_ready=1, s_ready=0, instr=0.
  - On accept: kind 0 -> FILL_L; kind 1 -> FILL_R; kind 2 -> latch cmd_op, load counter with EXEC_CYCLES, go to EXEC; kind 3 -> dropped, stay IDLE.
- FILL_x:
  - s_ready=1, cmd_ready=0.
  - Each accepted word is written to the staging slot given by the counter, then the counter increments.
  - Gaps in s_valid stall with no timeout.
  - FILL_L: on the 16th word -> COMMIT_L.
  - FILL_R: on the 16th word -> FILL_A, counter reset to 0.
  - FILL_A: on the 16th word -> COMMIT_RA.
- Output buses change only on commit; lvg never sees a partial tile. l_tile/r_tile/a_tile hold their value otherwise.
- COMMIT_L (one cycle): l_tile <= L staging; instr=1 for exactly this cycle; next state IDLE. instr returns to 0 in IDLE.
- COMMIT_RA (one cycle): r_tile and a_tile both update on the same edge; instr=2 for this cycle; next state IDLE.
- Load latency: the 16th (or 32nd) word accepted at edge t -> tiles updated and instr=1/2 during cycle t+1 -> cmd_ready high in cycle t+2.
- EXEC:
  - instr=latched op for exactly EXEC_CYCLES consecutive cycles; counter decrements each cycle.
  - Leaving with counter=1 -> CAPTURE.
  - op=0 still waits the full count.
- CAPTURE (one cycle): instr=0; res_data <= b_tile; res_valid=1 during the following cycle (in IDLE). res_data holds until the next EXEC capture.
- Only one command is in flight; no command queue.
- s_valid while not in FILL_x is ignored (s_ready=0).
- Counters are 5 bits; wrap cannot occur (max 16).

Decomposition:
- Shared header lvg_defs.vh:
  - TILE_W=512, ELEM_W=32, N_ELEM=16
  - kind codes KIND_LOAD_L/KIND_LOAD_RA/KIND_EXEC
  - INSTR_NOP=0, INSTR_LOAD_L=1, INSTR_LOAD_RA=2
  - state encodings
- One sub-module, lvg_tile_stage: 16x32 staging register with write-enable, index input and 512-bit flat output. Instantiated three times (L, R, A).

Test Plan:
1. Reset: rst high 2 cycles with s_valid=1 -> all tiles, instr and res_data are 0, s_ready=0, cmd_ready=1.
2. LOAD_L: stream 0x3f800000, 0x3f800000, then 14x 0x00000000, with s_valid deasserted for 3 cycles mid-stream -> l_tile[31:0]=l_tile[63:32]=0x3f800000, rest 0; instr=1 for exactly one cycle after the last word; l_tile unchanged before that cycle.
3. LOAD_RA: 16 words R (r11=0x3fce5aee ... r44=0), then 16 words A (a11=0xbfd2cfe4 ...) -> r_tile and a_tile update on the same edge; instr=2 for one cycle; busy deasserts the next cycle.
4. EXEC: op=8, EXEC_CYCLES=16, with b_tile driven to a known pattern k=element index -> instr=8 for exactly 16 cycles, then 0; res_valid pulses once; res_data equals the pattern; cmd_ready is low throughout.
5. Reset mid-FILL_A after 5 A words -> no commit, r_tile/a_tile=0, state IDLE; a subsequent LOAD_RA starts from word 0.
6. cmd_kind=3, then s_valid during IDLE -> no state change; instr stays 0; s_ready=0; next LOAD_L works normally.

Source files
------------

// File: rtl/lvg_feeder_pkg.sv
// lvg_feeder_pkg
// Shared definitions for the lvg operand feeder: tile geometry, command kind
// codes, the fixed lvg instruction codes the feeder emits itself, and the
// feeder state encoding. Imported by every other file of the feeder.
package lvg_feeder_pkg;

  localparam int ELEM_W = 32;
  localparam int N_ELEM = 16;
  localparam int TILE_W = ELEM_W * N_ELEM;
  localparam int CNT_W  = 5;

  // Index of the final element of a tile in the word counter's width.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

  typedef enum logic [1:0] {
    KIND_LOAD_L  = 2'd0,
    KIND_LOAD_RA = 2'd1,
    KIND_EXEC    = 2'd2,
    KIND_RSVD    = 2'd3
  } kind_e;

  localparam logic [7:0] INSTR_NOP     = 8'd0;
  localparam logic [7:0] INSTR_LOAD_L  = 8'd1;
  localparam logic [7:0] INSTR_LOAD_RA = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL_L    = 3'd1,
    ST_FILL_R    = 3'd2,
    ST_FILL_A    = 3'd3,
    ST_COMMIT_L  = 3'd4,
    ST_COMMIT_RA = 3'd5,
    ST_EXEC      = 3'd6,
    ST_CAPTURE   = 3'd7
  } state_e;

endpackage

// File: rtl/lvg_feeder_if.sv
// lvg_feeder_if
// Bundles everything that crosses the feeder boundary apart from clk/rst:
//   command channel : cmd_valid, cmd_kind, cmd_op  -> feeder ; cmd_ready <- feeder
//   operand stream  : s_valid, s_data              -> feeder ; s_ready   <- feeder
//   lvg side        : l_tile, r_tile, a_tile, instr <- feeder ; b_tile -> feeder
//   result / status : res_valid, res_data, busy     <- feeder
// master = the upstream controller (and lvg's result bus), slave = the feeder.
interface lvg_feeder_if;

  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [1:0]                        cmd_kind;
  logic [7:0]                        cmd_op;
  logic                              s_valid;
  logic                              s_ready;
  logic [lvg_feeder_pkg::ELEM_W-1:0] s_data;
  logic [lvg_feeder_pkg::TILE_W-1:0] l_tile;
  logic [lvg_feeder_pkg::TILE_W-1:0] r_tile;
  logic [lvg_feeder_pkg::TILE_W-1:0] a_tile;
  logic [7:0]                        instr;
  logic [lvg_feeder_pkg::TILE_W-1:0] b_tile;
  logic                              res_valid;
  logic [lvg_feeder_pkg::TILE_W-1:0] res_data;
  logic                              busy;

  modport master (
    output cmd_valid, cmd_kind, cmd_op, s_valid, s_data, b_tile,
    input  cmd_ready, s_ready, l_tile, r_tile, a_tile, instr,
           res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_op, s_valid, s_data, b_tile,
    output cmd_ready, s_ready, l_tile, r_tile, a_tile, instr,
           res_valid, res_data, busy
  );

endinterface

// File: rtl/lvg_tile_stage.sv
// lvg_tile_stage
// 16 x 32-bit staging register for one operand tile.
//   clk, rst : clock, synchronous active-high clear
//   we_i     : write the element selected by idx_i
//   idx_i    : element index (row-major, 0..15)
//   data_i   : element value
//   tile_o   : flat tile, element k at [32*k +: 32]; shows data_i in slot
//              idx_i while we_i is high so the final word can be committed
//              on the same edge it is accepted
module lvg_tile_stage
  import lvg_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [3:0]        idx_i,
  input  logic [ELEM_W-1:0] data_i,
  output logic [TILE_W-1:0] tile_o
);

  logic [TILE_W-1:0] mem_q;

  // Staging storage: one element written per accepted stream word.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[int'(idx_i)*ELEM_W +: ELEM_W] <= data_i;
    end
  end

  // Write-through view: the element being written this cycle already
  // appears in the flat output, letting the owner latch a complete tile
  // on the edge that accepts the last word.
  always_comb begin
    tile_o = mem_q;
    if (we_i) begin
      tile_o[int'(idx_i)*ELEM_W +: ELEM_W] = data_i;
    end
  end

endmodule

// File: rtl/lvg_feeder.sv
// lvg_feeder
// Command-driven front end for the lvg 4x4 fp32 matrix unit. Gathers
// word-serial operands into staging tiles, commits them atomically onto the
// L/R/A buses, drives lvg's instr port and captures the B result after an
// EXEC opcode has been held for EXEC_CYCLES cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lvg_feeder_if.slave (command, stream, lvg buses, result, busy)
module lvg_feeder
  import lvg_feeder_pkg::*;
#(
  parameter int EXEC_CYCLES = 16
)
(
  input  logic        clk,
  input  logic        rst,
  lvg_feeder_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         op_q, op_d;
  logic [TILE_W-1:0]  lTile_q, rTile_q, aTile_q, resData_q;
  logic               resValid_q;

  logic               cmdReady;
  logic               sReady;
  logic [7:0]         instrOut;
  logic               wordAcc;
  logic               lastWord;
  logic [TILE_W-1:0]  lStage, rStage, aStage;

  assign wordAcc  = bus.s_valid && sReady;
  assign lastWord = wordAcc && (cnt_q == LAST_IDX);

  lvg_tile_stage uStageL (
    .clk(clk), .rst(rst), .we_i(wordAcc && (state_q == ST_FILL_L)),
    .idx_i(cnt_q[3:0]), .data_i(bus.s_data), .tile_o(lStage)
  );
  lvg_tile_stage uStageR (
    .clk(clk), .rst(rst), .we_i(wordAcc && (state_q == ST_FILL_R)),
    .idx_i(cnt_q[3:0]), .data_i(bus.s_data), .tile_o(rStage)
  );
  lvg_tile_stage uStageA (
    .clk(clk), .rst(rst), .we_i(wordAcc && (state_q == ST_FILL_A)),
    .idx_i(cnt_q[3:0]), .data_i(bus.s_data), .tile_o(aStage)
  );

  // Control state, shared word/cycle counter and latched EXEC opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= INSTR_NOP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state and handshake/instr decode. The counter indexes stream words
  // during fills and counts down the opcode hold time during EXEC.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    cmdReady = 1'b0;
    sReady   = 1'b0;
    instrOut = INSTR_NOP;
    case (state_q)
      ST_IDLE: begin
        cmdReady = 1'b1;
        if (bus.cmd_valid) begin
          cnt_d = '0;
          case (kind_e'(bus.cmd_kind))
            KIND_LOAD_L:  state_d = ST_FILL_L;
            KIND_LOAD_RA: state_d = ST_FILL_R;
            KIND_EXEC: begin
              op_d    = bus.cmd_op;
              cnt_d   = CNT_W'(EXEC_CYCLES);
              state_d = ST_EXEC;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_FILL_L, ST_FILL_R, ST_FILL_A: begin
        sReady = 1'b1;
        if (wordAcc) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (lastWord) begin
          cnt_d = '0;
          case (state_q)
            ST_FILL_L: state_d = ST_COMMIT_L;
            ST_FILL_R: state_d = ST_FILL_A;
            default:   state_d = ST_COMMIT_RA;
          endcase
        end
      end
      ST_COMMIT_L: begin
        instrOut = INSTR_LOAD_L;
        state_d  = ST_IDLE;
      end
      ST_COMMIT_RA: begin
        instrOut = INSTR_LOAD_RA;
        state_d  = ST_IDLE;
      end
      ST_EXEC: begin
        instrOut = op_q;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand and result registers. Tiles are latched from the write-through
  // staging view on the edge that accepts the final word, so the new tile
  // and the matching load instruction appear together in the commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lTile_q    <= '0;
      rTile_q    <= '0;
      aTile_q    <= '0;
      resData_q  <= '0;
      resValid_q <= 1'b0;
    end else begin
      if ((state_q == ST_FILL_L) && lastWord) begin
        lTile_q <= lStage;
      end
      if ((state_q == ST_FILL_A) && lastWord) begin
        rTile_q <= rStage;
        aTile_q <= aStage;
      end
      if (state_q == ST_CAPTURE) begin
        resData_q <= bus.b_tile;
      end
      resValid_q <= (state_q == ST_CAPTURE);
    end
  end

  assign bus.cmd_ready = cmdReady;
  assign bus.s_ready   = sReady;
  assign bus.instr     = instrOut;
  assign bus.l_tile    = lTile_q;
  assign bus.r_tile    = rTile_q;
  assign bus.a_tile    = aTile_q;
  assign bus.res_data  = resData_q;
  assign bus.res_valid = resValid_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lvg_feeder.sv
// tb_lvg_feeder
// Self-checking bench for lvg_feeder: directed sequences, a table of
// command vectors and randomized commands compared with a word-level model
// of the L/R/A/result tiles.
module tb_lvg_feeder;
  import lvg_feeder_pkg::*;

  localparam int EXEC_N = 16;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] op;
    logic [7:0] expInstr;
    int         maxGap;
  } vec_t;

  logic clk;
  logic rst;

  lvg_feeder_if bus();

  lvg_feeder #(.EXEC_CYCLES(EXEC_N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] stimWords [32];
  logic [31:0] bWords    [16];
  logic [31:0] lModel    [16];
  logic [31:0] rModel    [16];
  logic [31:0] aModel    [16];
  logic [31:0] resModel  [16];

  // Row-major packing: element k lives at bits [32*k +: 32].
  function automatic logic [TILE_W-1:0] packTile(input logic [31:0] w [16]);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int k = 0; k < 16; k++) t[32*k +: 32] = w[k];
    return t;
  endfunction

  // The instruction value the feeder should present for each command kind.
  function automatic logic [7:0] refInstr(input logic [1:0] kind, input logic [7:0] op);
    case (kind)
      2'd0:    return 8'd1;
      2'd1:    return 8'd2;
      2'd2:    return op;
      default: return 8'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [TILE_W-1:0] got,
                             input logic [TILE_W-1:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic checkTiles(input string tag);
    checkOutput({tag, "_l_tile"},   bus.l_tile,   packTile(lModel));
    checkOutput({tag, "_r_tile"},   bus.r_tile,   packTile(rModel));
    checkOutput({tag, "_a_tile"},   bus.a_tile,   packTile(aModel));
    checkOutput({tag, "_res_data"}, bus.res_data, packTile(resModel));
  endtask

  task automatic clearModel();
    for (int k = 0; k < 16; k++) begin
      lModel[k] = '0; rModel[k] = '0; aModel[k] = '0; resModel[k] = '0;
    end
  endtask

  task automatic fillRandom();
    for (int k = 0; k < 32; k++) stimWords[k] = $urandom;
    for (int k = 0; k < 16; k++) bWords[k] = $urandom;
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    rst         = 1'b1;
    bus.s_valid = 1'b1;
    repeat (cycles) @(negedge clk);
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    clearModel();
  endtask

  task automatic sendCmd(input logic [1:0] kind, input logic [7:0] op);
    int waitCnt;
    waitCnt      = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_kind  = kind;
    bus.cmd_op    = op;
    while (bus.cmd_ready !== 1'b1 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 100) reportTimeout("cmd_accept");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] data, input int gap);
    int waitCnt;
    for (int g = 0; g < gap; g++) begin
      bus.s_valid = 1'b0;
      @(negedge clk);
    end
    waitCnt     = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    while (bus.s_ready !== 1'b1 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 100) reportTimeout("stream_accept");
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Run one full command using stimWords / bWords and check its effect.
  // gapAt >= 0 inserts three idle stream cycles before that word.
  task automatic applyStimulus(input logic [1:0] kind, input logic [7:0] op,
                               input logic [7:0] expInstr, input int maxGap,
                               input int gapAt);
    int nWords;
    int good;
    nWords = (kind == 2'd0) ? 16 : (kind == 2'd1) ? 32 : 0;
    bus.b_tile = packTile(bWords);
    sendCmd(kind, op);
    for (int k = 0; k < nWords; k++) begin
      if (k == nWords - 1) begin
        if (kind == 2'd0) checkOutput("l_tile_before_commit", bus.l_tile, packTile(lModel));
        else begin
          checkOutput("r_tile_before_commit", bus.r_tile, packTile(rModel));
          checkOutput("a_tile_before_commit", bus.a_tile, packTile(aModel));
        end
      end
      pushWord(stimWords[k], ((k == gapAt) ? 3 : 0) + $urandom_range(0, maxGap));
    end
    case (kind)
      2'd0, 2'd1: begin
        for (int k = 0; k < 16; k++) begin
          if (kind == 2'd0) lModel[k] = stimWords[k];
          else begin
            rModel[k] = stimWords[k];
            aModel[k] = stimWords[16 + k];
          end
        end
        checkOutput("commit_instr", TILE_W'(bus.instr), TILE_W'(expInstr));
        checkTiles("commit");
        @(negedge clk);
        checkOutput("post_commit_instr", TILE_W'(bus.instr), TILE_W'(0));
        checkOutput("post_commit_ready", TILE_W'({bus.cmd_ready, bus.busy}), TILE_W'(2'b10));
      end
      2'd2: begin
        good = 0;
        for (int i = 0; i < EXEC_N; i++) begin
          if (bus.instr === expInstr && bus.cmd_ready === 1'b0 &&
              bus.res_valid === 1'b0 && bus.busy === 1'b1) good++;
          @(negedge clk);
        end
        checkOutput("exec_hold_cycles", TILE_W'(good), TILE_W'(EXEC_N));
        checkOutput("capture_cycle", TILE_W'({bus.instr, bus.busy, bus.res_valid}),
                    TILE_W'({8'd0, 1'b1, 1'b0}));
        @(negedge clk);
        for (int k = 0; k < 16; k++) resModel[k] = bWords[k];
        checkOutput("res_valid_pulse", TILE_W'({bus.res_valid, bus.busy, bus.cmd_ready}),
                    TILE_W'(3'b101));
        checkTiles("exec");
        bus.b_tile = ~bus.b_tile;
        @(negedge clk);
        checkOutput("res_valid_drop", TILE_W'(bus.res_valid), TILE_W'(0));
        checkOutput("res_data_hold", bus.res_data, packTile(resModel));
      end
      default: begin
        checkOutput("rsvd_idle", TILE_W'({bus.busy, bus.cmd_ready, bus.instr}),
                    TILE_W'({1'b0, 1'b1, 8'd0}));
        bus.s_valid = 1'b1;
        bus.s_data  = $urandom;
        @(negedge clk);
        checkOutput("rsvd_s_ready", TILE_W'({bus.s_ready, bus.busy, bus.instr}), TILE_W'(0));
        bus.s_valid = 1'b0;
        checkTiles("rsvd");
      end
    endcase
  endtask

  vec_t vecs [8];

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int k0;
    logic [1:0] rk;
    logic [7:0] rop;

    bus.cmd_valid = 1'b0;
    bus.cmd_kind  = 2'd0;
    bus.cmd_op    = 8'd0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.b_tile    = '0;
    rst           = 1'b0;
    clearModel();

    // Reset with stream traffic present.
    applyReset(2);
    checkTiles("reset");
    checkOutput("reset_ctrl", TILE_W'({bus.instr, bus.s_ready, bus.cmd_ready,
                                       bus.res_valid, bus.busy}),
                TILE_W'({8'd0, 1'b0, 1'b1, 1'b0, 1'b0}));

    // LOAD_L with a stall in the middle of the stream.
    for (int k = 0; k < 32; k++) stimWords[k] = 32'h0;
    stimWords[0] = 32'h3f800000;
    stimWords[1] = 32'h3f800000;
    applyStimulus(2'd0, 8'h00, 8'd1, 0, 8);

    // LOAD_RA with hand-picked values.
    for (int k = 0; k < 16; k++) begin
      stimWords[k]      = (k == 15) ? 32'h0 : 32'h3fce5aee + 32'(k);
      stimWords[16 + k] = 32'hbfd2cfe4 - 32'(k * 3);
    end
    applyStimulus(2'd1, 8'h00, 8'd2, 1, -1);

    // EXEC op 8 with b element k = k.
    for (int k = 0; k < 16; k++) bWords[k] = 32'(k);
    applyStimulus(2'd2, 8'h08, 8'h08, 0, -1);

    // Reset in the middle of FILL_A, then a clean LOAD_RA.
    fillRandom();
    sendCmd(2'd1, 8'h00);
    for (int k = 0; k < 21; k++) pushWord(stimWords[k], 0);
    checkOutput("mid_fill_a_state", TILE_W'({bus.s_ready, bus.busy}), TILE_W'(2'b11));
    applyReset(1);
    checkTiles("mid_reset");
    checkOutput("mid_reset_idle", TILE_W'({bus.busy, bus.cmd_ready, bus.instr}),
                TILE_W'({1'b0, 1'b1, 8'd0}));
    fillRandom();
    applyStimulus(2'd1, 8'h00, 8'd2, 0, -1);

    // Reserved command and idle stream traffic, then a normal LOAD_L.
    applyStimulus(2'd3, 8'h5a, 8'd0, 0, -1);
    fillRandom();
    applyStimulus(2'd0, 8'h00, 8'd1, 2, -1);

    // Table of command vectors.
    vecs[0] = '{2'd0, 8'h00, 8'h01, 2};
    vecs[1] = '{2'd1, 8'h33, 8'h02, 3};
    vecs[2] = '{2'd2, 8'h08, 8'h08, 0};
    vecs[3] = '{2'd3, 8'h55, 8'h00, 0};
    vecs[4] = '{2'd2, 8'h00, 8'h00, 0};
    vecs[5] = '{2'd0, 8'ha5, 8'h01, 0};
    vecs[6] = '{2'd2, 8'hff, 8'hff, 0};
    vecs[7] = '{2'd1, 8'h00, 8'h02, 1};
    for (int v = 0; v < 8; v++) begin
      fillRandom();
      applyStimulus(vecs[v].kind, vecs[v].op, vecs[v].expInstr, vecs[v].maxGap, -1);
    end

    // Randomized command sequence against the model.
    for (int i = 0; i < 14; i++) begin
      fillRandom();
      rk  = 2'($urandom_range(0, 3));
      rop = 8'($urandom_range(0, 255));
      k0  = $urandom_range(0, 15);
      applyStimulus(rk, rop, refInstr(rk, rop), 2, k0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
